// File: rtl/eval_arbiter_if.sv
// eval_arbiter_if
//   Bundles the requester-side and evaluator-side signals of eval_arbiter.
//   Modport slave  : the arbiter itself (consumes requests and evaluator results,
//                    drives grants, responses and the evaluator inputs).
//   Modport master : the environment (requesters plus the shared evaluator).
//   Signals:
//     req / req_board / req_white_to_move / req_white_pop / req_black_pop  - per-slot requests
//     req_ack / rsp_valid                     - one-hot grant and result pulses
//     rsp_eval / rsp_material / rsp_insufficient / rsp_error - tagged result
//     busy / timeout_sticky                   - status
//     ev_*                                    - evaluator handshake and data
interface eval_arbiter_if #(
    parameter int EVAL_WIDTH  = 24,
    parameter int REQ_COUNT   = 4,
    parameter int BOARD_WIDTH = 256
);
    logic [REQ_COUNT-1:0]             req;
    logic [REQ_COUNT*BOARD_WIDTH-1:0] req_board;
    logic [REQ_COUNT-1:0]             req_white_to_move;
    logic [REQ_COUNT*6-1:0]           req_white_pop;
    logic [REQ_COUNT*6-1:0]           req_black_pop;
    logic [REQ_COUNT-1:0]             req_ack;
    logic [REQ_COUNT-1:0]             rsp_valid;
    logic signed [EVAL_WIDTH-1:0]     rsp_eval;
    logic signed [31:0]               rsp_material;
    logic                             rsp_insufficient;
    logic                             rsp_error;
    logic                             busy;
    logic                             timeout_sticky;
    logic                             ev_board_valid;
    logic [BOARD_WIDTH-1:0]           ev_board;
    logic                             ev_white_to_move;
    logic [5:0]                       ev_white_pop;
    logic [5:0]                       ev_black_pop;
    logic                             ev_clear_eval;
    logic                             ev_eval_valid;
    logic signed [EVAL_WIDTH-1:0]     ev_eval;
    logic signed [31:0]               ev_material;
    logic                             ev_insufficient;

    modport slave (
        input  req, req_board, req_white_to_move, req_white_pop, req_black_pop,
        input  ev_eval_valid, ev_eval, ev_material, ev_insufficient,
        output req_ack, rsp_valid, rsp_eval, rsp_material, rsp_insufficient, rsp_error,
        output busy, timeout_sticky,
        output ev_board_valid, ev_board, ev_white_to_move, ev_white_pop, ev_black_pop,
        output ev_clear_eval
    );

    modport master (
        output req, req_board, req_white_to_move, req_white_pop, req_black_pop,
        output ev_eval_valid, ev_eval, ev_material, ev_insufficient,
        input  req_ack, rsp_valid, rsp_eval, rsp_material, rsp_insufficient, rsp_error,
        input  busy, timeout_sticky,
        input  ev_board_valid, ev_board, ev_white_to_move, ev_white_pop, ev_black_pop,
        input  ev_clear_eval
    );
endinterface

// File: rtl/eval_arbiter.sv
// eval_arbiter
//   Round-robin scheduler sharing one evaluator among REQ_COUNT requesters.
//   Grants a request, latches its board/side/pops into the evaluator inputs,
//   runs the board_valid / eval_valid / clear_eval handshake with a watchdog,
//   and returns the tagged result to the granted slot.
//   Ports:
//     clk   - single clock
//     reset - asynchronous, active-high
//     bus   - eval_arbiter_if.slave (requests, responses, status, evaluator link)
module eval_arbiter #(
    parameter int EVAL_WIDTH     = 24,
    parameter int REQ_COUNT      = 4,
    parameter int TIMEOUT_CYCLES = 32,
    parameter int BOARD_WIDTH    = 256
) (
    input logic           clk,
    input logic           reset,
    eval_arbiter_if.slave bus
);
    localparam int IDX_W = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CLEAR,
        S_DRAIN
    } state_t;

    state_t state_reg, state_next;

    // grant_reg doubles as last_grant: it is the slot being served and the
    // round-robin pointer for the next arbitration.
    logic [IDX_W-1:0]             grant_reg, grant_next;
    logic [WD_W-1:0]              wd_reg, wd_next;
    logic [REQ_COUNT-1:0]         req_ack_reg, req_ack_next;
    logic [REQ_COUNT-1:0]         rsp_valid_reg, rsp_valid_next;
    logic signed [EVAL_WIDTH-1:0] rsp_eval_reg, rsp_eval_next;
    logic signed [31:0]           rsp_material_reg, rsp_material_next;
    logic                         rsp_insufficient_reg, rsp_insufficient_next;
    logic                         rsp_error_reg, rsp_error_next;
    logic                         busy_reg, busy_next;
    logic                         timeout_reg, timeout_next;
    logic                         ev_board_valid_reg, ev_board_valid_next;
    logic                         ev_clear_eval_reg, ev_clear_eval_next;
    logic [BOARD_WIDTH-1:0]       ev_board_reg, ev_board_next;
    logic                         ev_wtm_reg, ev_wtm_next;
    logic [5:0]                   ev_wpop_reg, ev_wpop_next;
    logic [5:0]                   ev_bpop_reg, ev_bpop_next;

    // Per-slot views of the flattened request buses.
    logic [BOARD_WIDTH-1:0] slot_board [REQ_COUNT];
    logic [5:0]             slot_wpop  [REQ_COUNT];
    logic [5:0]             slot_bpop  [REQ_COUNT];

    for (genvar gi = 0; gi < REQ_COUNT; gi++) begin : g_slot
        assign slot_board[gi] = bus.req_board[gi*BOARD_WIDTH +: BOARD_WIDTH];
        assign slot_wpop[gi]  = bus.req_white_pop[gi*6 +: 6];
        assign slot_bpop[gi]  = bus.req_black_pop[gi*6 +: 6];
    end

    // Round-robin pick: first set req at or after grant_reg+1, wrapping.
    logic [IDX_W:0]   cand;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= REQ_COUNT; k++) begin
            cand = {1'b0, grant_reg} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(REQ_COUNT)) begin
                cand = cand - (IDX_W+1)'(REQ_COUNT);
            end
            if (!pick_found && bus.req[cand[IDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_next            = state_reg;
        grant_next            = grant_reg;
        wd_next               = wd_reg;
        req_ack_next          = '0;
        rsp_valid_next        = '0;
        rsp_eval_next         = rsp_eval_reg;
        rsp_material_next     = rsp_material_reg;
        rsp_insufficient_next = rsp_insufficient_reg;
        rsp_error_next        = rsp_error_reg;
        timeout_next          = timeout_reg;
        ev_board_valid_next   = 1'b0;
        ev_clear_eval_next    = 1'b0;
        ev_board_next         = ev_board_reg;
        ev_wtm_next           = ev_wtm_reg;
        ev_wpop_next          = ev_wpop_reg;
        ev_bpop_next          = ev_bpop_reg;

        case (state_reg)
            S_IDLE: begin
                if (pick_found) begin
                    req_ack_next  = REQ_COUNT'(1) << pick_idx;
                    grant_next    = pick_idx;
                    ev_board_next = slot_board[pick_idx];
                    ev_wtm_next   = bus.req_white_to_move[pick_idx];
                    ev_wpop_next  = slot_wpop[pick_idx];
                    ev_bpop_next  = slot_bpop[pick_idx];
                    state_next    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                ev_board_valid_next = 1'b1;
                wd_next             = '0;
                state_next          = S_WAIT;
            end
            S_WAIT: begin
                wd_next = wd_reg + 1'b1;
                // A valid arriving on the timeout cycle still counts as a result.
                if (bus.ev_eval_valid) begin
                    rsp_eval_next         = bus.ev_eval;
                    rsp_material_next     = bus.ev_material;
                    rsp_insufficient_next = bus.ev_insufficient;
                    rsp_error_next        = 1'b0;
                    state_next            = S_CLEAR;
                end else if (wd_reg == WD_W'(TIMEOUT_CYCLES-1)) begin
                    rsp_eval_next         = '0;
                    rsp_material_next     = '0;
                    rsp_insufficient_next = 1'b0;
                    rsp_error_next        = 1'b1;
                    timeout_next          = 1'b1;
                    state_next            = S_CLEAR;
                end
            end
            S_CLEAR: begin
                ev_clear_eval_next = 1'b1;
                rsp_valid_next     = REQ_COUNT'(1) << grant_reg;
                state_next         = S_DRAIN;
            end
            S_DRAIN: begin
                // The evaluator's valid can linger after a clear; a new board
                // must not be issued until it has dropped.
                if (!bus.ev_eval_valid) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase

        busy_next = (state_next != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg            <= S_IDLE;
            grant_reg            <= IDX_W'(REQ_COUNT-1);
            wd_reg               <= '0;
            req_ack_reg          <= '0;
            rsp_valid_reg        <= '0;
            rsp_eval_reg         <= '0;
            rsp_material_reg     <= '0;
            rsp_insufficient_reg <= 1'b0;
            rsp_error_reg        <= 1'b0;
            busy_reg             <= 1'b0;
            timeout_reg          <= 1'b0;
            ev_board_valid_reg   <= 1'b0;
            ev_clear_eval_reg    <= 1'b0;
            ev_board_reg         <= '0;
            ev_wtm_reg           <= 1'b0;
            ev_wpop_reg          <= '0;
            ev_bpop_reg          <= '0;
        end else begin
            state_reg            <= state_next;
            grant_reg            <= grant_next;
            wd_reg               <= wd_next;
            req_ack_reg          <= req_ack_next;
            rsp_valid_reg        <= rsp_valid_next;
            rsp_eval_reg         <= rsp_eval_next;
            rsp_material_reg     <= rsp_material_next;
            rsp_insufficient_reg <= rsp_insufficient_next;
            rsp_error_reg        <= rsp_error_next;
            busy_reg             <= busy_next;
            timeout_reg          <= timeout_next;
            ev_board_valid_reg   <= ev_board_valid_next;
            ev_clear_eval_reg    <= ev_clear_eval_next;
            ev_board_reg         <= ev_board_next;
            ev_wtm_reg           <= ev_wtm_next;
            ev_wpop_reg          <= ev_wpop_next;
            ev_bpop_reg          <= ev_bpop_next;
        end
    end

    assign bus.req_ack          = req_ack_reg;
    assign bus.rsp_valid        = rsp_valid_reg;
    assign bus.rsp_eval         = rsp_eval_reg;
    assign bus.rsp_material     = rsp_material_reg;
    assign bus.rsp_insufficient = rsp_insufficient_reg;
    assign bus.rsp_error        = rsp_error_reg;
    assign bus.busy             = busy_reg;
    assign bus.timeout_sticky   = timeout_reg;
    assign bus.ev_board_valid   = ev_board_valid_reg;
    assign bus.ev_clear_eval    = ev_clear_eval_reg;
    assign bus.ev_board         = ev_board_reg;
    assign bus.ev_white_to_move = ev_wtm_reg;
    assign bus.ev_white_pop     = ev_wpop_reg;
    assign bus.ev_black_pop     = ev_bpop_reg;
endmodule

// File: doc/eval_arbiter.md
# eval_arbiter

Round-robin scheduler that shares a single `evaluate_general` instance among `REQ_COUNT` requesters, typically parallel move-generator slots or search workers. It arbitrates the requests and latches the winner's board and side information. It then sequences the evaluator's `board_valid` / `eval_valid` / `clear_eval` handshake and returns the tagged result to the granted requester. A watchdog bounds every evaluation so that a stuck evaluator cannot hang the search.

## Interface
Parameters:
- `EVAL_WIDTH`, 24: width of signed eval, matches evaluator.
- `REQ_COUNT`, 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, 32: maximum cycles in WAIT before abort, at least 8.

Ports:
- `clk`, input, 1: single clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `req`, input, `REQ_COUNT`: per-requester request level, held until `req_ack`.
- `req_board`, input, `REQ_COUNT*BOARD_WIDTH`: boards, slot i at `[i*BOARD_WIDTH +: BOARD_WIDTH]`.
- `req_white_to_move`, input, `REQ_COUNT`: side to move per slot.
- `req_white_pop`, input, `REQ_COUNT*6`: white mobility per slot.
- `req_black_pop`, input, `REQ_COUNT*6`: black mobility per slot.
- `req_ack`, output, `REQ_COUNT`: one-cycle grant pulse, one-hot.
- `rsp_valid`, output, `REQ_COUNT`: one-cycle result pulse, one-hot, to the granted slot.
- `rsp_eval`, output, `EVAL_WIDTH` signed: result eval.
- `rsp_material`, output, 32 signed: result material.
- `rsp_insufficient`, output, 1: insufficient-material flag.
- `rsp_error`, output, 1: result aborted by timeout.
- `busy`, output, 1: high in any state other than IDLE.
- `timeout_sticky`, output, 1: set on any timeout, cleared only by `reset`.
- `ev_board_valid`, output, 1: to evaluator `board_valid`.
- `ev_board`, output, `BOARD_WIDTH`: to evaluator `board`.
- `ev_white_to_move`, output, 1: to evaluator.
- `ev_white_pop`, output, 6: to evaluator.
- `ev_black_pop`, output, 6: to evaluator.
- `ev_clear_eval`, output, 1: to evaluator `clear_eval`.
- `ev_eval_valid`, input, 1: from evaluator.
- `ev_eval`, input, `EVAL_WIDTH`: from evaluator.
- `ev_material`, input, 32: from evaluator.
- `ev_insufficient`, input, 1: from evaluator.

## Operation
- State machine: IDLE -> ISSUE -> WAIT -> CLEAR -> DRAIN -> IDLE.
- **IDLE:**
  - If any `req` is set, pick the first set bit at or after `last_grant+1`, wrapping modulo `REQ_COUNT`.
  - Pulse `req_ack[g]`, latch that slot's board, side and pops into the `ev_*` registers, record `g`, then go to ISSUE.
  - `last_grant` resets to `REQ_COUNT-1`, so the first grant after reset goes to slot 0.
- **ISSUE:** `ev_board_valid`=1 for exactly one cycle, clear the watchdog, go to WAIT.
- **WAIT:**
  - The watchdog increments each cycle.
  - On `ev_eval_valid`=1, capture `ev_eval`/`ev_material`/`ev_insufficient`, set `rsp_error`=0, go to CLEAR.
  - If the watchdog reaches `TIMEOUT_CYCLES-1` with no valid, capture zeros, set `rsp_error`=1, set `timeout_sticky`, go to CLEAR.
  - If valid and timeout occur on the same cycle, valid wins.
- **CLEAR:** `ev_clear_eval`=1 for one cycle, pulse `rsp_valid[g]`, go to DRAIN.
- **DRAIN:** stay until `ev_eval_valid`=0, then go to IDLE. This guards against the evaluator's one-cycle-stale `eval_valid` after a clear.
- `ev_board` and the other `ev_*` data registers are held stable from ISSUE through DRAIN. The evaluator pipeline samples them continuously, so they must not change.
- `req` arriving or dropping during non-IDLE states is ignored until IDLE. Deasserting `req` before ack is permitted, and that slot is then skipped.
- `rsp_*` data registers hold their value until the next capture.

## Timing
- All outputs are registered. Reset values: `req_ack`=0, `rsp_valid`=0, `rsp_eval`=0, `rsp_material`=0, `rsp_insufficient`=0, `rsp_error`=0, `busy`=0, `timeout_sticky`=0, `ev_board_valid`=0, `ev_clear_eval`=0, all `ev_*` data=0. State resets to IDLE.
- Per-request timing:
  - `req_ack` occurs the cycle after `req` is sampled in IDLE.
  - `ev_board_valid` follows in the next cycle.
  - With the 5-cycle evaluator, `ev_eval_valid` arrives about 7 cycles after `ev_board_valid`.
  - `rsp_valid` fires 2 cycles after `ev_eval_valid` is sampled high.
- Throughput: one evaluation per roughly 12 cycles. There are no back-to-back grants: the minimum gap between `req_ack` pulses is 5 cycles plus the evaluator latency.
- Reset asserted mid-operation clears everything asynchronously. The evaluator shares `reset`, so no clear handshake is needed.

## Test plan
- Single request, slot 2, board with kings only, pops 0/0 -> `req_ack`=0b0100, one `ev_board_valid` pulse, `rsp_valid`=0b0100, `rsp_eval`=0, `rsp_insufficient`=1, `rsp_error`=0.
- All four `req` held continuously -> grants in order 0,1,2,3,0, with no `ev_board_valid` while `busy`, and each `rsp_valid` matching the preceding ack.
- Requests 1 and 3 pending after a slot-1 grant -> next grant goes to 3, then 1 (round-robin, no starvation).
- Evaluator model that never raises valid -> after 32 WAIT cycles `rsp_valid` pulses with `rsp_error`=1 and `rsp_eval`=0, `timeout_sticky`=1, `ev_clear_eval` pulses, and the next request is served normally.
- Evaluator model holding `eval_valid` 3 cycles after clear -> arbiter stays in DRAIN 3 cycles, and the next `ev_board_valid` occurs only after valid drops.
- `reset` asserted during WAIT -> all outputs 0 immediately, and the next request is granted to slot 0.
